// File: rtl/debug_slave_if.sv
// Ring and probe signals of one debug_slave node, with master and slave views.
// DEBUG_SLAVE_BITCNT_EN adds the bit_cntr/len_err diagnostic signals.
interface debug_slave_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  debug_di;
  logic                  debug_sl;
  logic                  debug_do;
  logic                  debug_sl_o;
  logic [DATA_WIDTH-1:0] dbg_in;
  logic [DATA_WIDTH-1:0] dbg_out;
  logic                  load_pulse;
`ifdef DEBUG_SLAVE_BITCNT_EN
  logic [7:0]            bit_cntr;
  logic                  len_err;

  modport slave (
    input  debug_di, debug_sl, dbg_in,
    output debug_do, debug_sl_o, dbg_out, load_pulse, bit_cntr, len_err
  );
  modport master (
    output debug_di, debug_sl, dbg_in,
    input  debug_do, debug_sl_o, dbg_out, load_pulse, bit_cntr, len_err
  );
`else
  modport slave (
    input  debug_di, debug_sl, dbg_in,
    output debug_do, debug_sl_o, dbg_out, load_pulse
  );
  modport master (
    output debug_di, debug_sl, dbg_in,
    input  debug_do, debug_sl_o, dbg_out, load_pulse
  );
`endif
endinterface

// File: rtl/debug_slave.sv
// Debug-ring node: a DATA_WIDTH shift register spliced into the serial ring, with load/shift commands.
// Optional DEBUG_SLAVE_BITCNT_EN adds a shift counter and a sticky ring-length error flag.
module debug_slave #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    SL_DELAY   = 1,
  parameter logic [DATA_WIDTH-1:0] DOUT_INIT  = '0
) (
  input logic          mclk,
  input logic          mrst,
  debug_slave_if.slave dbg
);

  typedef enum logic {IDLE, ARM} state_t;

  state_t                state_q, state_d;
  logic                  sl_d;
  logic                  do_shift, do_load;
  logic [DATA_WIDTH-1:0] sr;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  load_pulse_q;
  logic                  sl_o_q;

  // Command line alignment: the master budgets SL_DELAY cycles before decode
  generate
    if (SL_DELAY == 0) begin : g_sl_direct
      assign sl_d = dbg.debug_sl;
    end else begin : g_sl_pipe
      logic [SL_DELAY-1:0] sl_pipe;
      always_ff @(posedge mclk or posedge mrst) begin
        if (mrst) begin
          sl_pipe <= '0;
        end else begin
          sl_pipe[0] <= dbg.debug_sl;
          for (int i = 1; i < SL_DELAY; i++) begin
            sl_pipe[i] <= sl_pipe[i-1];
          end
        end
      end
      assign sl_d = sl_pipe[SL_DELAY-1];
    end
  endgenerate

  always_ff @(posedge mclk or posedge mrst) begin
    if (mrst) begin
      state_q <= IDLE;
      sl_o_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sl_o_q  <= dbg.debug_sl;
    end
  end

  // A 1 seen in ARM is always the qualifier, so a third consecutive 1 re-arms instead of reloading
  always_comb begin
    state_d  = IDLE;
    do_shift = 1'b0;
    do_load  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sl_d) state_d = ARM;
      end
      ARM: begin
        state_d  = IDLE;
        do_shift = ~sl_d;
        do_load  = sl_d;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mclk or posedge mrst) begin
    if (mrst) begin
      sr           <= '0;
      dout_q       <= DOUT_INIT;
      load_pulse_q <= 1'b0;
    end else begin
      load_pulse_q <= do_load;
      if (do_load) begin
        dout_q <= sr;
        sr     <= dbg.dbg_in;
      end else if (do_shift) begin
        sr <= (sr >> 1) | (DATA_WIDTH'(dbg.debug_di) << (DATA_WIDTH - 1));
      end
    end
  end

  assign dbg.debug_do   = sr[0];
  assign dbg.debug_sl_o = sl_o_q;
  assign dbg.dbg_out    = dout_q;
  assign dbg.load_pulse = load_pulse_q;

`ifdef DEBUG_SLAVE_BITCNT_EN
  logic [7:0] bit_cntr_q;
  logic       len_err_q;

  // A load after a shift count that is not a whole number of ring passes flags a host framing error
  always_ff @(posedge mclk or posedge mrst) begin
    if (mrst) begin
      bit_cntr_q <= 8'd0;
      len_err_q  <= 1'b0;
    end else if (do_load) begin
      bit_cntr_q <= 8'd0;
      if ((bit_cntr_q != 8'd0) && ((32'(bit_cntr_q) % 32'(DATA_WIDTH)) != 32'd0)) begin
        len_err_q <= 1'b1;
      end
    end else if (do_shift) begin
      bit_cntr_q <= bit_cntr_q + 8'd1;
    end
  end

  assign dbg.bit_cntr = bit_cntr_q;
  assign dbg.len_err  = len_err_q;
`endif

endmodule
